// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle MIPS core: Moore decode of every datapath
// strobe and select, plus combined PC enable, sticky illegal-opcode halt and retire counter.
module multicycle_controller #(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             op,
  input  logic                   zero,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   pcEn,
  output logic [1:0]             PCSource,
  output logic                   IorD,
  output logic                   memRead,
  output logic                   memWrite,
  output logic                   MemToReg,
  output logic                   IRWrite,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic                   illegalOp,
  output logic [COUNT_WIDTH-1:0] instrCount
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_JUMP, S_ADDIEX, S_ADDIWB, S_HALT
  } state_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDI  = 6'b001000,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   illegal_q, illegal_d;

  logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       mem_to_reg, ir_write, reg_write, reg_dst, alu_src_a;
  logic [1:0] pc_source, alu_src_b, alu_op;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        state_d = S_FETCH;
        count_d = count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
    if (reset) begin
      state_d   = S_FETCH;
      count_d   = '0;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    count_q   <= count_d;
    illegal_q <= illegal_d;
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_ADDIWB: reg_write = 1'b1;
      default: ;
    endcase
    // Reset overrides the registered state so the datapath sees idle strobes with FETCH selects.
    if (reset) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b01;
      alu_op        = 2'b00;
    end
  end

  assign PCWrite     = pc_write;
  assign PCWriteCond = pc_write_cond;
  assign pcEn        = pc_write | (pc_write_cond & zero);
  assign PCSource    = pc_source;
  assign IorD        = iord;
  assign memRead     = mem_read;
  assign memWrite    = mem_write;
  assign MemToReg    = mem_to_reg;
  assign IRWrite     = ir_write;
  assign RegWrite    = reg_write;
  assign RegDst      = reg_dst;
  assign ALUSrcA     = alu_src_a;
  assign ALUSrcB     = alu_src_b;
  assign ALUOp       = alu_op;
  assign illegalOp   = illegal_q;
  assign instrCount  = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle MIPS core; it is the driving end of the datapath control interface.
- Consumes the opcode and ALU zero flag from the datapath.
- Produces every per-cycle control strobe and mux select the datapath, ALU controller and memory need.
- Adds a combined PC enable, a sticky illegal-opcode halt and a retired-instruction counter.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- op  input  6  opcode field, instruction[31:26], from the datapath instruction register.
- zero  input  1  ALU zero flag.
- PCWrite  output  1  unconditional PC write.
- PCWriteCond  output  1  branch-conditional PC write.
- pcEn  output  1  PCWrite | (PCWriteCond & zero); drives the datapath PC enable.
- PCSource  output  2  next-PC select: 00 ALU result, 01 ALU-out register, 10 jump target.
- IorD  output  1  memory address select: 0 PC, 1 ALU-out register.
- memRead  output  1  memory read strobe.
- memWrite  output  1  memory write strobe.
- MemToReg  output  1  register write data select: 0 ALU-out register, 1 memory-data register.
- IRWrite  output  1  instruction register load.
- RegWrite  output  1  register file write.
- RegDst  output  1  destination register select: 0 rt, 1 rd.
- ALUSrcA  output  1  ALU A select: 0 PC, 1 register A.
- ALUSrcB  output  2  ALU B select: 00 register B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- ALUOp  output  2  to ALU controller: 00 add, 01 sub, 10 decode funct.
- illegalOp  output  1  sticky; set on an unsupported opcode.
- instrCount  output  COUNT_WIDTH  count of instructions retired.

Behaviour:
- Moore FSM: all outputs decode from the registered state only, except pcEn, which also uses zero combinationally.
- Supported opcodes: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, J 000010, ADDI 001000.
- States, their asserted outputs, and transitions. Any output not listed is 0.
  - FETCH: memRead=1, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1. Next: DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by op: LW/SW→MEMADR, RTYPE→EXEC, BEQ→BRANCH, J→JUMP, ADDI→ADDIEX, otherwise→HALT.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: LW→MEMRD, SW→MEMWR.
  - MEMRD: memRead=1, IorD=1. Next: MEMWB.
  - MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next: FETCH.
  - MEMWR: memWrite=1, IorD=1. Next: FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemToReg=0. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
  - JUMP: PCWrite=1, PCSource=10. Next: FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
  - HALT: all strobes 0; illegalOp=1. Stays in HALT until reset.
- Cycles per instruction: LW 5, SW 4, RTYPE 4, ADDI 4, BEQ 3, J 3.
- instrCount increments by 1 on the clock edge leaving MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB.
  - BEQ counts whether taken or not.
  - Wraps modulo 2^COUNT_WIDTH with no saturation.
  - HALT does not count.
- illegalOp is set on the edge DECODE→HALT and held until reset.
- While reset is high:
  - state←FETCH, instrCount←0, illegalOp←0 at each edge.
  - PCWrite, pcEn, IRWrite, RegWrite, memWrite and memRead are forced to 0 combinationally.
  - All selects hold their FETCH values.
- First FETCH after reset deassertion: on the first edge with reset low, the FETCH strobes take effect.
- Reset asserted mid-instruction (any state, including HALT): the instruction is abandoned, with no write and no count. The FSM returns to FETCH on the next edge.
- op is sampled only in DECODE and MEMADR; it is don't-care elsewhere.
- zero only affects pcEn when PCWriteCond=1.

Test Plan:
- Reset held 3 cycles, then released → all strobes 0 during reset; first cycle after release shows FETCH (memRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01); instrCount=0.
- op=100011 (LW) → states FETCH,DECODE,MEMADR,MEMRD,MEMWB over 5 cycles; MEMRD IorD=1, memRead=1; MEMWB RegWrite=1, MemToReg=1; instrCount 0→1.
- op=101011 (SW), then op=000000 (RTYPE) → SW takes 4 cycles with memWrite=1 only in MEMWR; RTYPE shows ALUOp=10 in EXEC and RegDst=1 with RegWrite=1 in ALUWB; instrCount=2 after 8 cycles.
- op=000100 (BEQ), run twice: zero=1 in BRANCH, then zero=0 in BRANCH → pcEn=1, PCSource=01 on the first; pcEn=0 on the second; both 3 cycles; instrCount +2.
- op=000010 (J), then op=111111 → J gives PCWrite=1, PCSource=10 in cycle 3; the illegal op enters HALT, illegalOp=1, no strobes for 20 cycles, instrCount frozen at 1; reset clears illegalOp and returns to FETCH.
- Reset asserted in MEMRD of an LW → no RegWrite ever asserted, instrCount stays 0, FSM in FETCH one edge after reset deassertion.
